// File: rtl/dmem_arbiter_if.sv
// Bundle between the two requesters (CPU, debug/loader), the arbiter and the
// single-port data memory. The arbiter takes the slave view.
interface dmem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_access_addr, mem_write_data, mem_write_en, mem_read,
    input  mem_read_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU and
// a debug/loader port. Each access runs IDLE -> ACCESS -> DONE (3 cycles).
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam int   NUM_REQ = 2;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                           state, state_nxt;
  acc_t [NUM_REQ-1:0]               acc_in;
  acc_t                             lat_q, lat_nxt;
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0]               ack_q, ack_nxt;
  logic [NUM_REQ-1:0][DATA_W-1:0]   rdata_q;
  logic                             owner_q, owner_nxt;
  logic                             last_q, last_nxt;
  logic                             win;
  logic                             cap_rd;
  logic                             busy;

  // Requester index 0 = CPU, 1 = debug.
  assign req       = {bus.dbg_req, bus.cpu_req};
  assign acc_in[0] = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
  assign acc_in[1] = {bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};

  // On a tie the requester not granted last wins; otherwise the lone requester.
  assign win = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_q;
    owner_nxt = owner_q;
    last_nxt  = last_q;
    ack_nxt   = '0;
    cap_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          lat_nxt   = acc_in[win];
          owner_nxt = win;
          last_nxt  = win;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt        = DONE;
        ack_nxt[owner_q] = 1'b1;
        cap_rd           = ~lat_q.we;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_q   <= '0;
      owner_q <= OWN_CPU;
      last_q  <= OWN_DBG;
      ack_q   <= '0;
    end else begin
      state   <= state_nxt;
      lat_q   <= lat_nxt;
      owner_q <= owner_nxt;
      last_q  <= last_nxt;
      ack_q   <= ack_nxt;
    end
  end

  // Read data is held per port until that port's next read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cap_rd && owner_q == i[0])
          rdata_q[i] <= bus.mem_read_data;
      end
    end
  end

  // Gating with rst keeps an ACCESS cycle that coincides with reset from writing.
  assign busy                = (state == ACCESS) & ~rst;
  assign bus.mem_access_addr = lat_q.addr;
  assign bus.mem_write_data  = lat_q.wdata;
  assign bus.mem_write_en    = busy & lat_q.we;
  assign bus.mem_read        = busy & ~lat_q.we;

  assign bus.cpu_ack   = ack_q[0];
  assign bus.dbg_ack   = ack_q[1];
  assign bus.cpu_rdata = rdata_q[0];
  assign bus.dbg_rdata = rdata_q[1];
  assign bus.cpu_stall = bus.cpu_req & ~ack_q[0];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected acks,
// a negedge monitor pops and compares whenever an ack appears.
module tb_dmem_arbiter;
  logic clk;
  logic rst;

  dmem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [15:0] rd;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          total;
  int          bad;
  int          wen_cnt;

  logic [15:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_write_en) mem[bus.mem_access_addr[7:0]] <= bus.mem_write_data;
  end
  assign bus.mem_read_data = mem[bus.mem_access_addr[7:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_write_en) wen_cnt++;
    if (bus.cpu_ack | bus.dbg_ack) begin
      chk("ack_excl", {31'd0, bus.cpu_ack & bus.dbg_ack}, 32'd0);
      chk("sb_has_entry", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("ack_port", {31'd0, bus.dbg_ack}, {31'd0, mon_e.port});
        chk("ack_rdata", {16'd0, bus.dbg_ack ? bus.dbg_rdata : bus.cpu_rdata}, {16'd0, mon_e.rd});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    cyc();
    pl_en   = 1'b0;
  endtask

  task automatic push(input logic p, input logic [15:0] d);
    exp_t e;
    e.port = p;
    e.rd   = d;
    sbq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    clk = 0; rst = 1; pl_en = 0; pl_addr = 0; pl_data = 0;
    total = 0; bad = 0; wen_cnt = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    cyc();
    preload(8'd2, 16'h0000);
    preload(8'd3, 16'h00A5);
    preload(8'd4, 16'h0044);
    preload(8'd5, 16'h0000);
    preload(8'd7, 16'h0077);
    rst = 0;

    // reset state
    @(negedge clk);
    chk("rst_cpu_ack", {31'd0, bus.cpu_ack}, 0);
    chk("rst_dbg_ack", {31'd0, bus.dbg_ack}, 0);
    chk("rst_cpu_rdata", {16'd0, bus.cpu_rdata}, 0);
    chk("rst_dbg_rdata", {16'd0, bus.dbg_rdata}, 0);
    chk("rst_addr", {16'd0, bus.mem_access_addr}, 0);
    chk("rst_wen", {31'd0, bus.mem_write_en}, 0);
    chk("rst_rd", {31'd0, bus.mem_read}, 0);
    chk("rst_stall", {31'd0, bus.cpu_stall}, 0);
    cyc();

    // CPU read of addr 3
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'd3;
    push(1'b0, 16'h00A5);
    @(negedge clk);
    chk("rd_c1_mem_read", {31'd0, bus.mem_read}, 0);
    chk("rd_c1_stall", {31'd0, bus.cpu_stall}, 1);
    cyc();
    @(negedge clk);
    chk("rd_c2_mem_read", {31'd0, bus.mem_read}, 1);
    chk("rd_c2_addr", {16'd0, bus.mem_access_addr}, 3);
    chk("rd_c2_stall", {31'd0, bus.cpu_stall}, 1);
    cyc();
    @(negedge clk);
    chk("rd_c3_ack", {31'd0, bus.cpu_ack}, 1);
    chk("rd_c3_stall", {31'd0, bus.cpu_stall}, 0);
    chk("rd_c3_mem_read", {31'd0, bus.mem_read}, 0);
    cyc();
    bus.cpu_req = 0;
    @(negedge clk);
    chk("idle_stall", {31'd0, bus.cpu_stall}, 0);

    // debug write of 0x1234 to addr 5
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 16'd5; bus.dbg_wdata = 16'h1234;
    push(1'b1, 16'h0000);
    w0 = wen_cnt;
    cyc();
    @(negedge clk);
    chk("wr_access_wen", {31'd0, bus.mem_write_en}, 1);
    cyc();
    @(negedge clk);
    chk("wr_done_wen", {31'd0, bus.mem_write_en}, 0);
    chk("wr_done_ack", {31'd0, bus.dbg_ack}, 1);
    cyc();
    bus.dbg_req = 0;
    chk("wr_wen_cycles", wen_cnt - w0, 1);
    chk("wr_mem5", {16'd0, mem[5]}, 32'h1234);
    chk("wr_cpu_rdata_kept", {16'd0, bus.cpu_rdata}, 32'h00A5);

    // both requesting from reset: CPU, DBG, CPU, DBG
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'd3;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 16'd5;
    rst = 1;
    cyc();
    rst = 0;
    push(1'b0, 16'h00A5);
    push(1'b1, 16'h1234);
    push(1'b0, 16'h00A5);
    push(1'b1, 16'h1234);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("rr_ack_cyc%0d", c), {31'd0, bus.cpu_ack | bus.dbg_ack}, {31'd0, (c % 3) == 0});
      cyc();
    end
    bus.cpu_req = 0; bus.dbg_req = 0;
    chk("rr_sb_drained", sbq.size(), 0);

    // CPU write to addr 2; inputs change during ACCESS
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'd2; bus.cpu_wdata = 16'hBEEF;
    push(1'b0, 16'h00A5);
    cyc();
    bus.cpu_addr = 16'd7; bus.cpu_wdata = 16'h0000;
    @(negedge clk);
    chk("hold_addr", {16'd0, bus.mem_access_addr}, 2);
    chk("hold_wdata", {16'd0, bus.mem_write_data}, 32'hBEEF);
    cyc();
    cyc();
    bus.cpu_req = 0;
    chk("hold_mem2", {16'd0, mem[2]}, 32'hBEEF);
    chk("hold_mem7", {16'd0, mem[7]}, 32'h0077);

    // reset during ACCESS of a write to addr 4
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'd4; bus.cpu_wdata = 16'h5555;
    cyc();
    rst = 1;
    @(negedge clk);
    chk("abort_wen", {31'd0, bus.mem_write_en}, 0);
    cyc();
    rst = 0;
    chk("abort_mem4", {16'd0, mem[4]}, 32'h0044);
    push(1'b0, 16'h0000);
    @(negedge clk);
    chk("abort_no_ack", {31'd0, bus.cpu_ack}, 0);
    cyc();
    @(negedge clk);
    chk("retry_wen", {31'd0, bus.mem_write_en}, 1);
    cyc();
    @(negedge clk);
    chk("retry_ack", {31'd0, bus.cpu_ack}, 1);
    cyc();
    bus.cpu_req = 0;
    chk("retry_mem4", {16'd0, mem[4]}, 32'h5555);
    @(negedge clk);
    chk("final_stall", {31'd0, bus.cpu_stall}, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, 16, data width of both requester ports and the memory port SHALL be DATA_W bits.
REQ-002 Parameter ADDR_W, 16, address width of both requester ports and the memory port SHALL be ADDR_W bits.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high; ports are clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-004 Port cpu_req, input, 1, SHALL be the CPU access request, held until cpu_ack.
REQ-005 Ports cpu_we (input, 1, write=1/read=0), cpu_addr (input, ADDR_W), cpu_wdata (input, DATA_W) SHALL carry the CPU access.
REQ-006 Ports cpu_ack (output, 1, one-cycle completion pulse), cpu_rdata (output, DATA_W, read data valid with cpu_ack), cpu_stall (output, 1, cpu_req & ~cpu_ack) SHALL report CPU status.
REQ-007 Ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata SHALL mirror the CPU port for the debug/loader requester.
REQ-008 Ports mem_access_addr (output, ADDR_W), mem_write_data (output, DATA_W), mem_write_en (output, 1), mem_read (output, 1), mem_read_data (input, DATA_W) SHALL drive the single-port data memory (synchronous write, combinational read).

Function
REQ-009 The FSM SHALL have states IDLE, ACCESS, DONE; one access completes per 3 cycles.
REQ-010 In IDLE, at a rising edge with any req high, the FSM SHALL latch the winner's we/addr/wdata, record the owner, and go to ACCESS; with no req it SHALL stay in IDLE.
REQ-011 Arbitration SHALL be round-robin: one requester high -> it wins; both high -> the requester not granted last wins; last-grant pointer updates on each grant.
REQ-012 In ACCESS, mem_access_addr and mem_write_data SHALL equal the latched values; mem_write_en = latched we; mem_read = ~latched we.
REQ-013 In IDLE and DONE, mem_write_en and mem_read SHALL be 0; mem_access_addr and mem_write_data SHALL hold the last latched values.
REQ-014 At the edge ending ACCESS, the FSM SHALL go to DONE and register mem_read_data into the owner's rdata (reads only; writes leave rdata unchanged).
REQ-015 In DONE, the owner's ack SHALL be 1 for exactly that cycle, the other ack 0; next state IDLE unconditionally.
REQ-016 req inputs SHALL be ignored in ACCESS and DONE; a requester that keeps req high after ack SHALL be re-arbitrated in the following IDLE.
REQ-017 Changes to we/addr/wdata after the grant edge SHALL not affect the in-flight access.
REQ-018 cpu_ack and dbg_ack SHALL never be high in the same cycle.
REQ-019 rdata outputs SHALL hold their value until the next read completion for that port.

Reset
REQ-020 At a rising edge with rst=1, state SHALL become IDLE, last-grant pointer = dbg (CPU wins first tie), acks = 0, rdata = 0, latched addr/wdata = 0, latched we = 0.
REQ-021 mem_write_en and mem_read SHALL be gated with ~rst, so an ACCESS cycle coinciding with rst performs no memory write.
REQ-022 Reset mid-operation SHALL abort the access with no ack issued; a held req SHALL be re-arbitrated in the first IDLE after rst falls.

Verification
REQ-023 Reset, then cpu_req=1, cpu_we=0, cpu_addr=3, mem[3]=16'h00A5 -> mem_read=1 in cycle 2, cpu_ack=1 and cpu_rdata=16'h00A5 in cycle 3, dbg_ack=0 throughout.
REQ-024 dbg write: dbg_we=1, addr=5, wdata=16'h1234 -> mem_write_en=1 for exactly one cycle, dbg_ack pulse one cycle later, mem[5]=16'h1234, cpu_rdata unchanged.
REQ-025 cpu_req and dbg_req both held high from reset for 12 cycles -> grants alternate CPU, DBG, CPU, DBG; acks at cycles 3, 6, 9, 12; never both in one cycle.
REQ-026 Grant CPU write addr=2, change cpu_addr to 7 and cpu_wdata in ACCESS -> write lands at addr 2 with the originally latched data.
REQ-027 Assert rst during ACCESS of a write to addr 4 -> mem[4] unchanged, no ack; after rst falls the held req completes normally 3 cycles after the first IDLE.
REQ-028 cpu_req high, dbg idle -> cpu_stall=1 in every cycle except the ack cycle; cpu_stall=0 whenever cpu_req=0.
